// File: rtl/pipe_mux_tree.sv
// -----------------------------------------------------------------------------
// pipe_mux_tree
// Pipelined N-way multiplexer tree with a valid/ready handshake.
// There is one register stage per select bit. Each stage halves the set of
// candidate words. Select bit 0 is resolved in stage 1. The last stage holds
// the single selected word.
// Each stage loads when it is empty or when the stage after it advances.
// As a result, bubbles collapse and a full, unstalled pipe moves one item per
// cycle.
//
// Optional feature, controlled by the macro PIPE_MUX_RR_EN:
//   undefined : in_sel chooses the forwarded word.
//   defined   : in_sel is ignored. An internal round-robin pointer supplies the
//               index. It advances once per accepted input and wraps to 0.
//               out_sel reports the index that was used.
// -----------------------------------------------------------------------------
module pipe_mux_tree #(
    parameter int SEL_BITS   = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [(1<<SEL_BITS)*DATA_WIDTH-1:0]    in_data,
    input  logic [SEL_BITS-1:0]                    in_sel,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [SEL_BITS-1:0]                    out_sel,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    localparam int N_IN = 1 << SEL_BITS;

    // Per-stage occupancy and load enables, indexed by stage number minus one.
    logic [SEL_BITS-1:0] valid_vec;
    logic [SEL_BITS-1:0] load_vec;

    // Index that enters the tree with the current input word.
    logic [SEL_BITS-1:0] sel_eff;
    logic                accept;

    assign accept   = in_valid && in_ready;
    assign in_ready = load_vec[0];

`ifdef PIPE_MUX_RR_EN
    logic [SEL_BITS-1:0] rr_ptr_reg;
    logic                unused_in_sel;

    // In round-robin mode the caller's select is intentionally ignored.
    assign unused_in_sel = ^in_sel;
    assign sel_eff       = rr_ptr_reg;

    // Round-robin pointer: advances only on a real transfer, so bubbles and stalls keep it put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (accept) begin
            rr_ptr_reg <= rr_ptr_reg + SEL_BITS'(1);
        end
    end
`else
    logic unused_accept;

    // In direct mode the handshake is consumed only by the first stage.
    assign unused_accept = accept;
    assign sel_eff       = in_sel;
`endif

    // Load chain, from the consumer backwards: a stage may load if it is empty or its successor loads.
    always_comb begin : p_load_chain
        logic run;
        run      = out_ready;
        load_vec = '0;
        for (int k = SEL_BITS - 1; k >= 0; k--) begin
            run         = !valid_vec[k] || run;
            load_vec[k] = run;
        end
    end

    // One tree level per iteration. Block gi is pipeline stage gi+1.
    for (genvar gi = 0; gi < SEL_BITS; gi++) begin : g_stage
        localparam int NW_IN  = N_IN >> gi;
        localparam int NW_OUT = N_IN >> (gi + 1);

        logic [NW_IN*DATA_WIDTH-1:0]  src_data;
        logic [SEL_BITS-1:0]          src_sel;
        logic                         src_valid;
        logic [NW_OUT*DATA_WIDTH-1:0] data_next;
        logic [NW_OUT*DATA_WIDTH-1:0] data_reg;
        logic [SEL_BITS-1:0]          sel_reg;
        logic                         valid_reg;
        logic                         load;

        // Stage 1 reads the input port. Later stages read the previous stage's registers.
        if (gi == 0) begin : g_src_in
            assign src_data  = in_data;
            assign src_sel   = sel_eff;
            assign src_valid = in_valid;
        end else begin : g_src_prev
            assign src_data  = g_stage[gi-1].data_reg;
            assign src_sel   = g_stage[gi-1].sel_reg;
            assign src_valid = g_stage[gi-1].valid_reg;
        end

        assign load          = load_vec[gi];
        assign valid_vec[gi] = valid_reg;

        // Bank of 2:1 muxes: word j picks between candidates 2j and 2j+1 using select bit gi.
        always_comb begin
            data_next = '0;
            for (int j = 0; j < NW_OUT; j++) begin
                data_next[j*DATA_WIDTH +: DATA_WIDTH] = src_sel[gi]
                    ? src_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]
                    : src_data[(2*j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Stage register: the valid flag follows upstream on load. The payload updates only for a real item.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
                sel_reg   <= '0;
            end else if (load) begin
                valid_reg <= src_valid;
                if (src_valid) begin
                    data_reg <= data_next;
                    sel_reg  <= src_sel;
                end
            end
        end
    end

    // The last stage has exactly one word left. It drives the consumer side directly from registers.
    assign out_data  = g_stage[SEL_BITS-1].data_reg;
    assign out_sel   = g_stage[SEL_BITS-1].sel_reg;
    assign out_valid = valid_vec[SEL_BITS-1];

endmodule

// File: tb/tb_pipe_mux_tree.sv
// -----------------------------------------------------------------------------
// tb_pipe_mux_tree
// Uses two instances of the design:
//   dut_a: SEL_BITS=2, DATA_WIDTH=8, for the directed scenarios.
//   dut_b: SEL_BITS=3, DATA_WIDTH=16, for the long randomized run.
// Expected values come from queue-based models. The index the model predicts is
// either the caller's select or the count of accepted items modulo N.
// The round-robin checks run when PIPE_MUX_RR_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_mux_tree;

    localparam int A_SB = 2;
    localparam int A_DW = 8;
    localparam int A_N  = 4;
    localparam int B_SB = 3;
    localparam int B_DW = 16;
    localparam int B_N  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [A_N*A_DW-1:0] a_in_data;
    logic [A_SB-1:0]     a_in_sel;
    logic                a_in_valid, a_in_ready;
    logic [A_DW-1:0]     a_out_data;
    logic [A_SB-1:0]     a_out_sel;
    logic                a_out_valid, a_out_ready;

    logic [B_N*B_DW-1:0] b_in_data;
    logic [B_SB-1:0]     b_in_sel;
    logic                b_in_valid, b_in_ready;
    logic [B_DW-1:0]     b_out_data;
    logic [B_SB-1:0]     b_out_sel;
    logic                b_out_valid, b_out_ready;

    pipe_mux_tree #(.SEL_BITS(A_SB), .DATA_WIDTH(A_DW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    pipe_mux_tree #(.SEL_BITS(B_SB), .DATA_WIDTH(B_DW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int checks = 0;
    int passed = 0;
    int acc_a  = 0;   // items accepted by dut_a since the last reset
    int acc_b  = 0;   // items accepted by dut_b since the last reset

    // Model: the index a new item will carry
    function automatic int pick_a(input int sel);
`ifdef PIPE_MUX_RR_EN
        return acc_a % A_N;
`else
        return sel;
`endif
    endfunction

    function automatic int pick_b(input int sel);
`ifdef PIPE_MUX_RR_EN
        return acc_b % B_N;
`else
        return sel;
`endif
    endfunction

    // Fixed words used by the directed tests: word i = 0x11*(i+1)
    function automatic logic [A_DW-1:0] word_a(input int i);
        return A_DW'(17 * (i + 1));
    endfunction

    task automatic idle_inputs();
        a_in_data   = 32'h44332211;
        a_in_sel    = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = '0;
        b_in_sel    = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); else passed++;
        checks++; if (a_out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", a_out_data); else passed++;
        checks++; if (a_out_sel !== 2'd0) $display("FAIL reset_out_sel: got %0d expected 0", a_out_sel); else passed++;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); else passed++;
        checks++; if (b_out_valid !== 1'b0 || b_out_data !== 16'h0) $display("FAIL reset_b_out: got v=%b d=%h expected v=0 d=0000", b_out_valid, b_out_data); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        acc_a = 0;
        acc_b = 0;
    endtask

    // Single item, sel=2: the result appears exactly SEL_BITS cycles after acceptance.
    task automatic test_single();
        int idx;
        @(negedge clk);
        a_in_data = 32'h44332211; a_in_sel = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL single_in_ready: got %b expected 1", a_in_ready); else passed++;
        idx = pick_a(2);
        acc_a++;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", a_out_valid); else passed++;
        @(negedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b1) $display("FAIL single_latency_valid: got %b expected 1", a_out_valid); else passed++;
        checks++; if (a_out_data !== word_a(idx)) $display("FAIL single_data: got %h expected %h", a_out_data, word_a(idx)); else passed++;
        checks++; if (a_out_sel !== A_SB'(idx)) $display("FAIL single_sel: got %0d expected %0d", a_out_sel, idx); else passed++;
        $display("[single] out data=%h sel=%0d (accepted #%0d)", a_out_data, a_out_sel, acc_a);
        @(negedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL single_consumed: got %b expected 0", a_out_valid); else passed++;
    endtask

    // Selects 0..3 on consecutive cycles: in_ready stays high and outputs stream out on consecutive cycles.
    task automatic test_back_to_back();
        int qi[$];
        int e;
        bit exp_v;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            if (t < 4) begin
                a_in_valid = 1'b1;
                a_in_sel   = A_SB'(t);
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (t < 4) begin
                checks++; if (a_in_ready !== 1'b1) $display("FAIL b2b_in_ready t=%0d: got %b expected 1", t, a_in_ready); else passed++;
                qi.push_back(pick_a(t));
                acc_a++;
            end
            exp_v = (t >= 2 && t <= 5);
            checks++; if (a_out_valid !== exp_v) $display("FAIL b2b_out_valid t=%0d: got %b expected %b", t, a_out_valid, exp_v); else passed++;
            if (a_out_valid && qi.size() > 0) begin
                e = qi.pop_front();
                checks++; if (a_out_data !== word_a(e) || a_out_sel !== A_SB'(e)) $display("FAIL b2b_out t=%0d: got %h/%0d expected %h/%0d", t, a_out_data, a_out_sel, word_a(e), e); else passed++;
                $display("[b2b] out data=%h sel=%0d", a_out_data, a_out_sel);
            end
        end
    endtask

    // Consumer stalled from the start: two items fill the pipe, the third waits, then all drain in order.
    task automatic test_stall();
        logic [A_DW-1:0] qd[$];
        int qs[$];
        int sent = 0;
        int got  = 0;
        int e;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            a_out_ready = (t >= 4);
            a_in_valid  = (sent < 3);
            a_in_sel    = A_SB'(sent);
            #1;
            if (t == 0 || t == 1 || t == 4) begin
                checks++; if (a_in_ready !== 1'b1) $display("FAIL stall_in_ready_hi t=%0d: got %b expected 1", t, a_in_ready); else passed++;
            end
            if (t == 2 || t == 3) begin
                checks++; if (a_in_ready !== 1'b0) $display("FAIL stall_in_ready_lo t=%0d: got %b expected 0", t, a_in_ready); else passed++;
                checks++; if (a_out_valid !== 1'b1 || qd.size() == 0 || a_out_data !== qd[0]) $display("FAIL stall_hold t=%0d: got v=%b d=%h expected held first item", t, a_out_valid, a_out_data); else passed++;
            end
            if (a_out_valid && a_out_ready) begin
                if (qd.size() == 0) begin
                    checks++; $display("FAIL stall_extra_output: got d=%h expected none", a_out_data);
                end else begin
                    e = qs.pop_front();
                    checks++; if (a_out_data !== qd[0] || a_out_sel !== A_SB'(e)) $display("FAIL stall_order: got %h/%0d expected %h/%0d", a_out_data, a_out_sel, qd[0], e); else passed++;
                    void'(qd.pop_front());
                    got++;
                    $display("[stall] out data=%h sel=%0d", a_out_data, a_out_sel);
                end
            end
            if (a_in_valid && a_in_ready) begin
                e = pick_a(sent);
                qs.push_back(e);
                qd.push_back(word_a(e));
                acc_a++;
                sent++;
            end
        end
        checks++; if (got !== 3) $display("FAIL stall_count: got %0d expected 3", got); else passed++;
    endtask

    // Reset while two items are in flight: outputs clear at once, and nothing stale appears afterwards.
    task automatic test_reset_midstream();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_sel = A_SB'(t + 1); a_out_ready = 1'b1;
            #1;
            acc_a++;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", a_out_valid); else passed++;
        checks++; if (a_out_data !== 8'h00 || a_out_sel !== 2'd0) $display("FAIL midrst_data: got %h/%0d expected 00/0", a_out_data, a_out_sel); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        acc_a = 0;
        acc_b = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            #1;
            checks++; if (a_out_valid !== 1'b0) $display("FAIL midrst_stale t=%0d: got %b expected 0", t, a_out_valid); else passed++;
        end
        $display("[midrst] pipeline flushed by reset");
    endtask

`ifdef PIPE_MUX_RR_EN
    // in_sel tied to 3: out_sel must follow 0,1,2,3,0,1 no matter where the stall cycles fall.
    task automatic test_round_robin();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        int sent = 0;
        int got  = 0;
        for (int t = 0; t < 80 && got < 6; t++) begin
            @(negedge clk);
            a_in_sel    = 2'd3;
            a_in_valid  = (sent < 6) && ($urandom_range(0, 1) == 1);
            a_out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (a_out_valid && a_out_ready) begin
                checks++; if (a_out_sel !== A_SB'(exp_seq[got]) || a_out_data !== word_a(exp_seq[got])) $display("FAIL rr_seq #%0d: got %0d/%h expected %0d/%h", got, a_out_sel, a_out_data, exp_seq[got], word_a(exp_seq[got])); else passed++;
                $display("[rr] out data=%h sel=%0d", a_out_data, a_out_sel);
                got++;
            end
            if (a_in_valid && a_in_ready) begin
                sent++;
                acc_a++;
            end
        end
        checks++; if (got !== 6) $display("FAIL rr_count: got %0d expected 6", got); else passed++;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask
`endif

    // Long random run on the 8-way, 16-bit instance, checked against an in-order queue model.
    task automatic test_random();
        logic [B_DW-1:0] qd[$];
        int qs[$];
        int qc[$];
        int last_stall = -1;
        int got = 0;
        int lat_checks = 0;
        bit prev_hold = 1'b0;
        logic [B_DW-1:0] prev_d = '0;
        logic [B_SB-1:0] prev_s = '0;
        int e;
        int c;
        int phase;
        bit draining;
        for (int t = 0; t < 10030; t++) begin
            @(negedge clk);
            draining = (t >= 10000);
            phase = (t / 300) % 3;
            for (int w = 0; w < B_N; w++) b_in_data[w*B_DW +: B_DW] = B_DW'($urandom);
            b_in_sel   = B_SB'($urandom);
            b_in_valid = !draining && ($urandom_range(0, 3) != 0);
            if (draining || phase == 0) b_out_ready = 1'b1;
            else if (phase == 1)        b_out_ready = ($urandom_range(0, 9) < 7);
            else                        b_out_ready = ($urandom_range(0, 3) == 0);
            #1;
            if (prev_hold) begin
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== prev_d || b_out_sel !== prev_s) $display("FAIL rand_hold t=%0d: got v=%b %h/%0d expected v=1 %h/%0d", t, b_out_valid, b_out_data, b_out_sel, prev_d, prev_s); else passed++;
            end
            if (!b_out_ready) last_stall = t;
            if (b_out_valid && b_out_ready) begin
                if (qd.size() == 0) begin
                    checks++; $display("FAIL rand_extra_output t=%0d: got %h expected none", t, b_out_data);
                end else begin
                    e = qs.pop_front();
                    c = qc.pop_front();
                    checks++; if (b_out_data !== qd[0] || b_out_sel !== B_SB'(e)) $display("FAIL rand_out t=%0d: got %h/%0d expected %h/%0d", t, b_out_data, b_out_sel, qd[0], e); else passed++;
                    void'(qd.pop_front());
                    if (last_stall <= c) begin
                        lat_checks++;
                        checks++; if (t - c !== B_SB) $display("FAIL rand_latency t=%0d: got %0d expected %0d", t, t - c, B_SB); else passed++;
                    end
                    got++;
                    $display("[rand] out #%0d data=%h sel=%0d lat=%0d", got, b_out_data, b_out_sel, t - c);
                end
            end
            prev_hold = b_out_valid && !b_out_ready;
            prev_d    = b_out_data;
            prev_s    = b_out_sel;
            if (b_in_valid && b_in_ready) begin
                e = pick_b(int'(b_in_sel));
                qs.push_back(e);
                qd.push_back(b_in_data[e*B_DW +: B_DW]);
                qc.push_back(t);
                acc_b++;
            end
        end
        checks++; if (qd.size() !== 0 || b_out_valid !== 1'b0) $display("FAIL rand_drain: got %0d pending v=%b expected 0 pending v=0", qd.size(), b_out_valid); else passed++;
        checks++; if (lat_checks == 0) $display("FAIL rand_latency_coverage: got 0 unstalled items expected >0"); else passed++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
`ifdef PIPE_MUX_RR_EN
        test_round_robin();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
